// File: rtl/usr_pkg.sv
// Shared types for the universal shift register sequencer.
package usr_pkg;

    // Immediate operation selected by SEL while idle
    typedef enum logic [1:0] {
        LOAD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        HOLD = 2'b11
    } sel_t;

    // Bit shifted in during a multi-step shift
    typedef enum logic [1:0] {
        SERIAL = 2'b00,
        ZERO   = 2'b01,
        ARITH  = 2'b10,
        ROT    = 2'b11
    } fill_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit entering the register. msb is Q[0] and lsb is Q[WIDTH-1].
    // dir is 0 for right and 1 for left.
    function automatic logic fill_bit(fill_t f, logic dir, logic ser,
                                      logic msb, logic lsb);
        logic b;
        case (f)
            SERIAL:  b = ser;
            ZERO:    b = 1'b0;
            ARITH:   b = dir ? 1'b0 : msb;
            default: b = dir ? msb : lsb;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/usr_cnt.sv
// Loadable down-counter holding the remaining shift count.
module usr_cnt #(
    parameter int CNTW = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            load,
    input  logic            dec,
    input  logic [CNTW-1:0] din,
    output logic [CNTW-1:0] cnt,
    output logic            zero
);

    // Load takes precedence over decrement. The count saturates at zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            cnt <= '0;
        else if (load)
            cnt <= din;
        else if (dec && !zero)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/usr_seq.sv
// Universal shift register. It performs one immediate op per idle cycle,
// or a counted multi-step shift that is started by START.
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CNTW  = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [0:WIDTH-1] D,
    input  logic            S0,
    input  logic            S3,
    input  logic [0:1]      SEL,
    input  logic            START,
    input  logic [0:CNTW-1] COUNT,
    input  logic            DIR,
    input  logic [0:1]      FILL,
    output logic [0:WIDTH-1] Q,
    output logic            SOL,
    output logic            SOR,
    output logic            BUSY,
    output logic            DONE
);

    state_t          state;
    logic            dir_r;
    fill_t           fill_r;
    logic [CNTW-1:0] cnt;
    logic            cnt_zero;
    logic            cnt_load;
    logic            cnt_dec;
    logic            last;
    logic            fb;
    logic [0:WIDTH-1] shifted;

    // Any START seen while idle reloads the count. A count of zero is harmless.
    assign cnt_load = (state == IDLE) && START;
    assign cnt_dec  = (state == SHIFT);
    assign last     = (cnt == CNTW'(1));

    usr_cnt #(.CNTW(CNTW)) u_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .din   (COUNT),
        .cnt   (cnt),
        .zero  (cnt_zero)
    );

    // The serial fill samples S0 or S3 live on every step.
    assign fb      = fill_bit(fill_r, dir_r, dir_r ? S3 : S0, Q[0], Q[WIDTH-1]);
    assign shifted = dir_r ? {Q[1:WIDTH-1], fb} : {fb, Q[0:WIDTH-2]};

    assign SOL = Q[0];
    assign SOR = Q[WIDTH-1];

    // Control FSM and datapath. BUSY and DONE are registered. DONE is a single-cycle strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            Q      <= '0;
            dir_r  <= 1'b0;
            fill_r <= SERIAL;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        dir_r  <= DIR;
                        fill_r <= fill_t'(FILL);
                        if (COUNT == '0) begin
                            DONE <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            BUSY  <= 1'b1;
                        end
                    end else begin
                        case (sel_t'(SEL))
                            LOAD:    Q <= D;
                            SHR:     Q <= {S0, Q[0:WIDTH-2]};
                            SHL:     Q <= {Q[1:WIDTH-1], S3};
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // The zero guard only matters if the count is somehow lost.
                    // In that case the block drops back to idle and does not shift.
                    if (!cnt_zero)
                        Q <= shifted;
                    if (last || cnt_zero) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_seq.sv
// Randomized self-checking bench for usr_seq at its default width (36) and count width (6).
module tb_usr_seq;

    localparam int W  = 36;
    localparam int CW = 6;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [0:W-1]  D;
    logic          S0, S3;
    logic [0:1]    SEL;
    logic          START;
    logic [0:CW-1] COUNT;
    logic          DIR;
    logic [0:1]    FILL;
    logic [0:W-1]  Q;
    logic          SOL, SOR, BUSY, DONE;

    usr_seq #(.WIDTH(W), .CNTW(CW)) dut (
        .CLK(CLK), .RESET(RESET), .D(D), .S0(S0), .S3(S3), .SEL(SEL),
        .START(START), .COUNT(COUNT), .DIR(DIR), .FILL(FILL),
        .Q(Q), .SOL(SOL), .SOR(SOR), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [35:0] m_q;   // model register, bit 35 corresponds to Q[0]

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    // Closed-form result of n shifts. sq holds the serial bits in the order they enter.
    function automatic logic [35:0] expect_multi(input logic [35:0] q, input int n,
                                                 input bit dir, input logic [1:0] fill,
                                                 input bit sq[$]);
        logic [35:0] r;
        int k;
        case (fill)
            2'd1: r = dir ? (q << n) : (q >> n);
            2'd2: r = dir ? (q << n) : 36'($signed(q) >>> n);
            2'd3: begin
                k = n % W;
                if (k == 0) r = q;
                else if (dir) r = (q << k) | (q >> (W - k));
                else          r = (q >> k) | (q << (W - k));
            end
            default: begin
                r = q;
                foreach (sq[i])
                    r = dir ? {r[34:0], sq[i]} : {sq[i], r[35:1]};
            end
        endcase
        return r;
    endfunction

    task automatic idle_op(input logic [1:0] sel, input logic [35:0] d, input bit s0, input bit s3);
        SEL = sel; D = d; S0 = s0; S3 = s3; START = 1'b0;
        @(negedge CLK);
        case (sel)
            2'd0: m_q = d;
            2'd1: m_q = {s0, m_q[35:1]};
            2'd2: m_q = {m_q[34:0], s3};
            default: ;
        endcase
        chk("idle_q",    Q,    m_q);
        chk("idle_sol",  SOL,  m_q[35]);
        chk("idle_sor",  SOR,  m_q[0]);
        chk("idle_busy", BUSY, 0);
        chk("idle_done", DONE, 0);
    endtask

    task automatic multi(input int n, input bit dir, input logic [1:0] fill,
                         input logic [1:0] sel, input bit restart);
        bit          sq[$];
        logic [35:0] q0;
        q0 = m_q;
        START = 1'b1; COUNT = CW'(n); DIR = dir; FILL = fill; SEL = sel;
        D = rnd36(); S0 = 1'($urandom); S3 = 1'($urandom);
        @(negedge CLK);
        START = 1'b0;
        chk("start_q", Q, m_q);
        if (n == 0) begin
            chk("zc_busy", BUSY, 0);
            chk("zc_done", DONE, 1);
            return;
        end
        chk("start_busy", BUSY, 1);
        chk("start_done", DONE, 0);
        for (int k = 0; k < n; k++) begin
            S0 = 1'($urandom); S3 = 1'($urandom);
            sq.push_back(dir ? S3 : S0);
            SEL = 2'($urandom); D = rnd36();
            START = (restart && k == 0) || ($urandom_range(3) == 0);
            COUNT = CW'($urandom); DIR = 1'($urandom); FILL = 2'($urandom);
            @(negedge CLK);
            if (k < n - 1) begin
                chk("run_busy", BUSY, 1);
                chk("run_done", DONE, 0);
            end else begin
                m_q = expect_multi(q0, n, dir, fill, sq);
                chk("end_busy", BUSY, 0);
                chk("end_done", DONE, 1);
                chk("end_q",    Q,    m_q);
            end
        end
        START = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; D = '0; S0 = 0; S3 = 0; SEL = 2'd3; START = 0;
        COUNT = '0; DIR = 0; FILL = 2'd0;
        m_q = '0;
        #12;
        chk("rst_q",    Q,    0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Serial right shift while idle, starting from zero
        for (int i = 0; i < 4; i++) idle_op(2'd1, rnd36(), 1'b1, 1'($urandom));
        chk("shr4_q",   Q,   36'hF00000000);
        chk("shr4_sor", SOR, 0);

        // Arithmetic right shift by 3
        idle_op(2'd0, 36'o400000000001, 0, 0);
        multi(3, 1'b0, 2'd2, 2'd3, 1'b0);
        chk("arith3_q", Q, 36'o740000000000);
        idle_op(2'd3, rnd36(), 0, 0);

        // Left rotate by the full width
        idle_op(2'd0, 36'o000000000007, 0, 0);
        multi(36, 1'b1, 2'd3, 2'd3, 1'b0);
        chk("rot36_q", Q, 36'o000000000007);

        // A zero count produces DONE only
        multi(0, 1'b0, 2'd1, 2'd0, 1'b0);
        idle_op(2'd3, rnd36(), 0, 0);

        // START with SEL=LOAD in the same cycle, then a second START while busy
        idle_op(2'd0, rnd36(), 0, 0);
        multi(4, 1'b0, 2'd1, 2'd0, 1'b1);
        idle_op(2'd3, rnd36(), 0, 0);

        // Reset asserted during the second busy cycle of a 5-step shift
        idle_op(2'd0, rnd36() | 36'h1, 0, 0);
        START = 1'b1; COUNT = CW'(5); DIR = 0; FILL = 2'd3;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("abort_q",    Q,    0);
        chk("abort_busy", BUSY, 0);
        m_q = '0;
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) idle_op(2'd3, rnd36(), 0, 0);

        // Random mix of idle ops and multi-step shifts, including back-to-back STARTs
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) < 7)
                idle_op(2'($urandom), rnd36(), 1'($urandom), 1'($urandom));
            else
                multi($urandom_range(0, 63), 1'($urandom), 2'($urandom),
                      2'($urandom), 1'($urandom));
        end
        idle_op(2'd3, rnd36(), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
